shift_unit_arbiter: RTL

- Shares one 8-bit general shifter (funnel-based: logical/arithmetic right, logical left, rotate) between NREQ requesters.
- Each requester has its own valid/ready request channel. All requesters share one response channel, tagged with the requester id.
- Grants are round-robin. A two-stage pipeline (operand register, result register) sustains one shift per cycle.
- Sits between the ALU-side requesters and the shifter datapath. It owns operand decoding into the shifter's ar/lr/rot controls.

---
 rtl/shift_pkg.sv | 46 ++++
 rtl/shift_unit_arbiter_if.sv | 33 +++
 rtl/general_shifter.sv | 26 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/shift_unit_arbiter.sv | 101 ++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared types, widths and op decoding for the shift unit arbiter.
//   shift_op_t  : 3-bit op encoding (LSR, ASR, LSL, ROR, ROL; 5..7 illegal)
//   shift_ctl_t : shifter controls {ar, lr, rot} plus illegal flag
//   op_ctl()    : op -> shift_ctl_t
//   clamp_amt() : saturates a 4-bit amount to AMT_MAX
package shift_pkg;

    localparam int SHIFT_W = 8;
    localparam int AMT_W   = 4;
    localparam logic [AMT_W-1:0] AMT_MAX = 4'd8;

    typedef enum logic [2:0] {
        LSR = 3'd0,
        ASR = 3'd1,
        LSL = 3'd2,
        ROR = 3'd3,
        ROL = 3'd4
    } shift_op_t;

    typedef struct packed {
        logic ar;
        logic lr;
        logic rot;
        logic illegal;
    } shift_ctl_t;

    function automatic shift_ctl_t op_ctl(shift_op_t op);
        shift_ctl_t c;
        case (op)
            LSR:     c = 4'b0000;
            ASR:     c = 4'b1000;
            LSL:     c = 4'b0100;
            ROR:     c = 4'b0010;
            ROL:     c = 4'b0110;
            default: c = 4'b0001;
        endcase
        return c;
    endfunction

    // Amounts above AMT_MAX must never reach the shifter: the left path
    // computes AMT_MAX - amt, which would wrap.
    function automatic logic [AMT_W-1:0] clamp_amt(logic [AMT_W-1:0] a);
        return (a > AMT_MAX) ? AMT_MAX : a;
    endfunction

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// shift_unit_arbiter_if: request/response bus between requesters and the shift unit arbiter.
//   req_*  : per-requester valid/ready channel, fields packed per requester
//   resp_* : shared response channel tagged with requester id
//   busy   : pipeline holds a valid entry
//   master : requester/consumer side; slave : arbiter side
interface shift_unit_arbiter_if
    import shift_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [3*NREQ-1:0]       req_op;
    logic [SHIFT_W*NREQ-1:0] req_data;
    logic [AMT_W*NREQ-1:0]   req_amt;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [IDW-1:0]          resp_id;
    logic [SHIFT_W-1:0]      resp_data;
    logic                    resp_err;
    logic                    busy;

    modport master (
        output req_valid, req_op, req_data, req_amt, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_data, req_amt, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_err, busy
    );
endinterface

// File: rtl/general_shifter.sv
// general_shifter: 8-bit funnel shifter (logical/arithmetic right, logical left, rotate).
//   data_i : operand     amt_i : amount, 0..AMT_MAX only
//   ar_i   : sign fill   lr_i  : left     rot_i : rotate
//   data_o : result
module general_shifter
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] data_i,
    input  logic [AMT_W-1:0]   amt_i,
    input  logic               ar_i,
    input  logic               lr_i,
    input  logic               rot_i,
    output logic [SHIFT_W-1:0] data_o
);
    logic [SHIFT_W-1:0] hi, lo;
    logic [AMT_W-1:0]   s;

    // Right shifts funnel {fill, data} by amt; left shifts funnel
    // {data, fill} by AMT_MAX - amt.
    always_comb begin
        hi     = (lr_i | rot_i) ? data_i : (ar_i ? {SHIFT_W{data_i[SHIFT_W-1]}} : '0);
        lo     = lr_i ? (rot_i ? data_i : '0) : data_i;
        s      = lr_i ? AMT_MAX - amt_i : amt_i;
        data_o = SHIFT_W'({hi, lo} >> s);
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first asserted request strictly after ptr_i.
//   req_i : request vector       ptr_i : last granted index
//   en_i  : grant allowed         gnt_o : one-hot grant (0 when !en_i)
//   idx_o : index of the winner (valid when any request is set)
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        // Scan from farthest to nearest so the nearest hit after ptr_i wins.
        for (int i = NREQ; i >= 1; i--) begin
            if (req_i[(int'(ptr_i) + i) % NREQ]) idx_o = IDW'((int'(ptr_i) + i) % NREQ);
        end
        gnt_o[idx_o] = en_i & req_i[idx_o];
    end
endmodule

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin sharing of one shifter between NREQ requesters.
//   clk  : rising-edge clock    nrst : synchronous active-low reset
//   bus  : slave side of shift_unit_arbiter_if (requests in, tagged responses out)
// Pipeline: S1 holds {id, op, data, clamped amt}; S2 holds {id, result, err}
// and drives the response channel.
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    shift_unit_arbiter_if.slave  bus
);
    logic               s1_valid_q, s1_valid_d;
    logic [IDW-1:0]     s1_id_q, s1_id_d;
    logic [2:0]         s1_op_q, s1_op_d;
    logic [SHIFT_W-1:0] s1_data_q, s1_data_d;
    logic [AMT_W-1:0]   s1_amt_q, s1_amt_d;
    logic               s2_valid_q, s2_valid_d;
    logic [IDW-1:0]     s2_id_q, s2_id_d;
    logic [SHIFT_W-1:0] s2_data_q, s2_data_d;
    logic               s2_err_q, s2_err_d;
    logic [IDW-1:0]     ptr_q, ptr_d;

    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               s1_load, s2_load, accept;
    shift_ctl_t         ctl;
    logic [SHIFT_W-1:0] sh_out;

    assign s2_load = s1_valid_q & (~s2_valid_q | bus.resp_ready);
    assign s1_load = ~s1_valid_q | s2_load;
    assign accept  = |gnt;
    assign ctl     = op_ctl(shift_op_t'(s1_op_q));

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .en_i  (s1_load),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    general_shifter u_shift (
        .data_i (s1_data_q),
        .amt_i  (s1_amt_q),
        .ar_i   (ctl.ar),
        .lr_i   (ctl.lr),
        .rot_i  (ctl.rot),
        .data_o (sh_out)
    );

    // accept implies s1_load, so the S1 payload only needs accept.
    always_comb begin
        ptr_d      = accept ? gnt_idx : ptr_q;
        s1_valid_d = s1_load ? accept : s1_valid_q;
        s1_id_d    = accept ? gnt_idx : s1_id_q;
        s1_op_d    = accept ? bus.req_op[3*gnt_idx +: 3] : s1_op_q;
        s1_data_d  = accept ? bus.req_data[SHIFT_W*gnt_idx +: SHIFT_W] : s1_data_q;
        s1_amt_d   = accept ? clamp_amt(bus.req_amt[AMT_W*gnt_idx +: AMT_W]) : s1_amt_q;
        s2_valid_d = s2_load | (s2_valid_q & ~bus.resp_ready);
        s2_id_d    = s2_load ? s1_id_q : s2_id_q;
        s2_data_d  = s2_load ? (ctl.illegal ? s1_data_q : sh_out) : s2_data_q;
        s2_err_d   = s2_load ? ctl.illegal : s2_err_q;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_op_q    <= '0;
            s1_data_q  <= '0;
            s1_amt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
            ptr_q      <= IDW'(NREQ - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_op_q    <= s1_op_d;
            s1_data_q  <= s1_data_d;
            s1_amt_q   <= s1_amt_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_data_q  <= s2_data_d;
            s2_err_q   <= s2_err_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = s2_valid_q;
    assign bus.resp_id    = s2_id_q;
    assign bus.resp_data  = s2_data_q;
    assign bus.resp_err   = s2_err_q;
    assign bus.busy       = s1_valid_q | s2_valid_q;
endmodule
